// File: rtl/accel_spi_sched.sv
`default_nettype none
//==============================================================================
// accel_spi_sched - init writes, host register port and periodic Y sampler
// sharing one SPI byte engine, one transaction in flight.            rev 1.0
//==============================================================================
module accel_spi_sched #(
  parameter int          SAMPLE_DIV  = 500000,
  parameter int          TIMEOUT_CYC = 2000000,
  parameter logic [7:0]  PWR_VAL     = 8'h08,
  parameter logic [7:0]  FMT_VAL     = 8'h01,
  parameter logic [5:0]  SAMPLE_ADDR = 6'h34
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_host_req,
  input  logic       i_host_rw,
  input  logic [5:0] i_host_addr,
  input  logic [7:0] i_host_wdata,
  output logic       o_host_ack,
  output logic [7:0] o_host_rdata,
  output logic       o_spi_start,
  output logic       o_spi_rw,
  output logic [5:0] o_spi_addr,
  output logic [7:0] o_spi_wdata,
  input  logic       i_spi_busy,
  input  logic       i_spi_done,
  input  logic [7:0] i_spi_rdata,
  output logic [7:0] o_sample_y,
  output logic       o_sample_valid,
  output logic       o_init_done,
  output logic       o_overrun,
  output logic       o_timeout_err
);

  localparam int c_TIMER_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int c_TCNT_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(SAMPLE_DIV - 1);
  localparam logic [c_TCNT_W-1:0]  c_TCNT_LAST  = c_TCNT_W'(TIMEOUT_CYC - 1);
  localparam logic [5:0] c_ADDR_PWR = 6'h2D;
  localparam logic [5:0] c_ADDR_FMT = 6'h31;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;
  typedef enum logic [1:0] {J_INIT = 2'd0, J_HOST = 2'd1, J_SAMPLE = 2'd2} job_t;

  state_t               r_state;
  job_t                 r_job;
  logic                 r_init_step;
  logic                 r_init_done;
  logic                 r_sample_pend;
  logic                 r_overrun;
  logic                 r_timeout_err;
  logic [c_TIMER_W-1:0] r_timer;
  logic [c_TCNT_W-1:0]  r_tcnt;
  logic                 r_host_ack;
  logic [7:0]           r_host_rdata;
  logic                 r_spi_start;
  logic                 r_spi_rw;
  logic [5:0]           r_spi_addr;
  logic [7:0]           r_spi_wdata;
  logic [7:0]           r_sample_y;
  logic                 r_sample_valid;

  logic w_wrap;
  logic w_idle_go;
  logic w_host_ok;
  logic w_pick_init;
  logic w_pick_host;
  logic w_pick_samp;

  // A host request is still high during its own ack cycle; skip it there.
  assign w_wrap      = (r_timer == c_TIMER_LAST);
  assign w_idle_go   = (r_state == S_IDLE) && !i_spi_busy;
  assign w_host_ok   = r_init_done && i_host_req && !r_host_ack;
  assign w_pick_init = w_idle_go && !r_init_done;
  assign w_pick_host = w_idle_go && w_host_ok;
  assign w_pick_samp = w_idle_go && r_init_done && !w_host_ok && r_sample_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer       <= '0;
      r_sample_pend <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_timer <= w_wrap ? '0 : r_timer + 1'b1;
      if (w_wrap) begin
        r_sample_pend <= 1'b1;
        if (r_sample_pend && !w_pick_samp) r_overrun <= 1'b1;
      end else if (w_pick_samp) begin
        r_sample_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_job          <= J_INIT;
      r_init_step    <= 1'b0;
      r_init_done    <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_tcnt         <= '0;
      r_host_ack     <= 1'b0;
      r_host_rdata   <= 8'h00;
      r_spi_start    <= 1'b0;
      r_spi_rw       <= 1'b0;
      r_spi_addr     <= 6'h00;
      r_spi_wdata    <= 8'h00;
      r_sample_y     <= 8'h00;
      r_sample_valid <= 1'b0;
    end else begin
      r_spi_start    <= 1'b0;
      r_host_ack     <= 1'b0;
      r_sample_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_init) begin
            r_job       <= J_INIT;
            r_spi_rw    <= 1'b0;
            r_spi_addr  <= r_init_step ? c_ADDR_FMT : c_ADDR_PWR;
            r_spi_wdata <= r_init_step ? FMT_VAL : PWR_VAL;
            r_spi_start <= 1'b1;
            r_state     <= S_ISSUE;
          end else if (w_pick_host) begin
            r_job       <= J_HOST;
            r_spi_rw    <= i_host_rw;
            r_spi_addr  <= i_host_addr;
            r_spi_wdata <= i_host_wdata;
            r_spi_start <= 1'b1;
            r_state     <= S_ISSUE;
          end else if (w_pick_samp) begin
            r_job       <= J_SAMPLE;
            r_spi_rw    <= 1'b1;
            r_spi_addr  <= SAMPLE_ADDR;
            r_spi_wdata <= 8'h00;
            r_spi_start <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_tcnt  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_spi_done) begin
            r_state <= S_IDLE;
            case (r_job)
              J_HOST: begin
                r_host_ack   <= 1'b1;
                r_host_rdata <= r_spi_rw ? i_spi_rdata : 8'h00;
              end
              J_SAMPLE: begin
                r_sample_y     <= i_spi_rdata;
                r_sample_valid <= 1'b1;
              end
              default: begin
                if (r_init_step) r_init_done <= 1'b1;
                else             r_init_step <= 1'b1;
              end
            endcase
          end else if (r_tcnt == c_TCNT_LAST) begin
            // Init keeps its step so it is retried; a sample is simply dropped.
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
            if (r_job == J_HOST) begin
              r_host_ack   <= 1'b1;
              r_host_rdata <= 8'hFF;
            end
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_host_ack     = r_host_ack;
  assign o_host_rdata   = r_host_rdata;
  assign o_spi_start    = r_spi_start;
  assign o_spi_rw       = r_spi_rw;
  assign o_spi_addr     = r_spi_addr;
  assign o_spi_wdata    = r_spi_wdata;
  assign o_sample_y     = r_sample_y;
  assign o_sample_valid = r_sample_valid;
  assign o_init_done    = r_init_done;
  assign o_overrun      = r_overrun;
  assign o_timeout_err  = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_accel_spi_sched.sv
`default_nettype none
//==============================================================================
// tb_accel_spi_sched - directed/random bench with engine model and job checker.
//==============================================================================
module tb_accel_spi_sched;
  localparam int SDIV = 100;
  localparam int TOUT = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       host_req, host_rw;
  logic [5:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic       spi_start, spi_rw;
  logic [5:0] spi_addr;
  logic [7:0] spi_wdata;
  logic       spi_busy, spi_done;
  logic [7:0] spi_rdata;
  logic [7:0] sample_y;
  logic       sample_valid, init_done, overrun, timeout_err;

  accel_spi_sched #(.SAMPLE_DIV(SDIV), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .rst(rst),
    .i_host_req(host_req), .i_host_rw(host_rw), .i_host_addr(host_addr),
    .i_host_wdata(host_wdata), .o_host_ack(host_ack), .o_host_rdata(host_rdata),
    .o_spi_start(spi_start), .o_spi_rw(spi_rw), .o_spi_addr(spi_addr),
    .o_spi_wdata(spi_wdata), .i_spi_busy(spi_busy), .i_spi_done(spi_done),
    .i_spi_rdata(spi_rdata), .o_sample_y(sample_y), .o_sample_valid(sample_valid),
    .o_init_done(init_done), .o_overrun(overrun), .o_timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rw;
    logic [5:0] addr;
    logic [7:0] wdata;
    int         cyc;
  } txn_t;

  txn_t       starts[$];
  txn_t       last;
  txn_t       newt;
  logic [7:0] last_rdata = 8'h00;
  int         last_done_cyc = 0;
  logic       hang = 1'b0;
  logic       force_busy = 1'b0;
  logic       eng_busy = 1'b0;
  int         eng_left = 0;
  bit         first_sample = 1'b1;
  bit         host_out = 1'b0;
  logic       prev_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Engine: done 10 cycles after start; ignores starts while hang is set.
  // Also checks every sample_valid against the transaction that produced it.
  initial begin
    spi_busy  = 1'b0;
    spi_done  = 1'b0;
    spi_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      spi_done = 1'b0;
      if (rst) begin
        eng_busy   = 1'b0;
        eng_left   = 0;
        prev_valid = 1'b0;
      end else begin
        if (sample_valid) begin
          chk("valid_job", 32'({last.rw, last.addr}), 32'({1'b1, 6'h34}));
          chk("valid_data", 32'(sample_y), 32'(last_rdata));
          chk("valid_latency", 32'(cyc), 32'(last_done_cyc + 1));
          chk("valid_pulse", 32'(prev_valid), 32'd0);
        end
        prev_valid = sample_valid;
        if (host_ack) chk("ack_unrequested", 32'(host_out), 32'd1);
        if (eng_busy) begin
          eng_left--;
          if (eng_left == 0) begin
            chk("spi_hold", 32'({spi_rw, spi_addr, spi_wdata}),
                32'({last.rw, last.addr, last.wdata}));
            spi_rdata = (last.addr == 6'h34 && first_sample) ? 8'hE0 : 8'($urandom);
            if (last.addr == 6'h34) first_sample = 1'b0;
            last_rdata    = spi_rdata;
            last_done_cyc = cyc;
            spi_done      = 1'b1;
            eng_busy      = 1'b0;
          end
        end
        if (spi_start) begin
          newt.rw    = spi_rw;
          newt.addr  = spi_addr;
          newt.wdata = spi_wdata;
          newt.cyc   = cyc;
          last       = newt;
          starts.push_back(newt);
          if (!hang) begin
            eng_busy = 1'b1;
            eng_left = 10;
          end
        end
      end
      spi_busy = eng_busy | force_busy;
    end
  end

  task automatic wait_start(output txn_t t, input int lim);
    int n = 0;
    while (starts.size() == 0 && n < lim) begin step(); n++; end
    if (starts.size() == 0) begin
      chk("start_seen", 32'(starts.size()), 32'd1);
      t = '{1'b0, 6'h00, 8'h00, 0};
    end else begin
      t = starts.pop_front();
    end
  endtask

  task automatic wait_valid(input int lim);
    int n = 0;
    while (!sample_valid && n < lim) begin step(); n++; end
    chk("valid_seen", 32'(sample_valid), 32'd1);
  endtask

  // Expected host result: read returns engine data, write returns 0, timeout FF.
  task automatic host_txn(input logic rw, input logic [5:0] a, input logic [7:0] wd,
                          input bit expect_to);
    int n = 0;
    int d;
    host_rw = rw; host_addr = a; host_wdata = wd; host_req = 1'b1; host_out = 1'b1;
    while (!host_ack && n < 400) begin step(); n++; end
    chk("host_ack_seen", 32'(host_ack), 32'd1);
    if (host_ack) begin
      chk("host_fields", 32'({last.rw, last.addr, last.wdata}), 32'({rw, a, wd}));
      if (expect_to) begin
        d = cyc - last.cyc;
        chk("host_to_rdata", 32'(host_rdata), 32'hFF);
        chk("host_to_latency", 32'(d >= TOUT && d <= TOUT + 2), 32'd1);
      end else begin
        chk("host_rdata", 32'(host_rdata), rw ? 32'(last_rdata) : 32'd0);
        chk("host_ack_latency", 32'(cyc), 32'(last_done_cyc + 1));
      end
    end
    host_req = 1'b0;
    step();
    chk("host_ack_pulse", 32'(host_ack), 32'd0);
    host_out = 1'b0;
  endtask

  initial begin
    txn_t t;
    int   c0;
    int   n;
    rst = 1'b1; host_req = 1'b0; host_rw = 1'b0; host_addr = 6'h00; host_wdata = 8'h00;
    repeat (3) step();
    chk("rst_host_spi", 32'({host_ack, host_rdata, spi_start, spi_rw, spi_addr, spi_wdata}), 32'd0);
    chk("rst_status", 32'({sample_y, sample_valid, init_done, overrun, timeout_err}), 32'd0);

    // Host request raised before init completes must wait for both init writes.
    host_rw = 1'b1; host_addr = 6'h00; host_wdata = 8'h00; host_req = 1'b1; host_out = 1'b1;
    rst = 1'b0;
    wait_start(t, 50);
    chk("init_write1", 32'({t.rw, t.addr, t.wdata}), 32'({1'b0, 6'h2D, 8'h08}));
    wait_start(t, 50);
    chk("init_write2", 32'({t.rw, t.addr, t.wdata}), 32'({1'b0, 6'h31, 8'h01}));
    host_txn(1'b1, 6'h00, 8'h00, 1'b0);
    chk("init_done", 32'(init_done), 32'd1);
    wait_start(t, 10);
    chk("host_after_init", 32'({t.rw, t.addr}), 32'({1'b1, 6'h00}));

    // Sampler alone: reads of 0x34 exactly every SDIV cycles, first returns E0.
    starts.delete();
    wait_start(t, 150);
    chk("sample_job", 32'({t.rw, t.addr}), 32'({1'b1, 6'h34}));
    c0 = t.cyc;
    wait_valid(40);
    chk("sample_e0", 32'(sample_y), 32'hE0);
    for (int i = 0; i < 2; i++) begin
      wait_start(t, 150);
      chk("sample_job_n", 32'({t.rw, t.addr}), 32'({1'b1, 6'h34}));
      chk("sample_period", 32'(t.cyc - c0), 32'(SDIV));
      c0 = t.cyc;
    end
    wait_valid(40);

    // Host and pending sample compete: host first, then the sample.
    force_busy = 1'b1;
    repeat (100) step();
    starts.delete();
    host_rw = 1'b1; host_addr = 6'h00; host_wdata = 8'h00; host_req = 1'b1; host_out = 1'b1;
    step();
    force_busy = 1'b0;
    host_txn(1'b1, 6'h00, 8'h00, 1'b0);
    wait_start(t, 10);
    chk("prio_host_first", 32'({t.rw, t.addr}), 32'({1'b1, 6'h00}));
    wait_start(t, 30);
    chk("prio_sample_next", 32'({t.rw, t.addr}), 32'({1'b1, 6'h34}));
    chk("no_overrun_yet", 32'(overrun), 32'd0);

    // Random host traffic interleaved with the running sampler.
    for (int i = 0; i < 8; i++) begin
      n = $urandom_range(0, 120);
      repeat (n) step();
      host_txn(1'($urandom), 6'($urandom_range(0, 63)), 8'($urandom), 1'b0);
    end

    // Engine held busy over two ticks: overrun, and the pending sample still runs.
    force_busy = 1'b1;
    repeat (210) step();
    chk("overrun", 32'(overrun), 32'd1);
    starts.delete();
    force_busy = 1'b0;
    wait_start(t, 40);
    chk("sample_after_busy", 32'({t.rw, t.addr}), 32'({1'b1, 6'h34}));
    wait_valid(40);

    // Engine never answers: host gets FF and timeout_err latches.
    hang = 1'b1;
    host_txn(1'b1, 6'($urandom_range(0, 63)), 8'h00, 1'b1);
    chk("timeout_err", 32'(timeout_err), 32'd1);

    // Reset while waiting on a hung transaction; init restarts and retries.
    starts.delete();
    wait_start(t, 200);
    repeat (5) step();
    rst = 1'b1;
    repeat (2) step();
    chk("rst2_host_spi", 32'({host_ack, host_rdata, spi_start, spi_rw, spi_addr, spi_wdata}), 32'd0);
    chk("rst2_status", 32'({sample_y, sample_valid, init_done, overrun, timeout_err}), 32'd0);
    starts.delete();
    rst = 1'b0;
    wait_start(t, 50);
    chk("reinit_write1", 32'({t.rw, t.addr, t.wdata}), 32'({1'b0, 6'h2D, 8'h08}));
    c0 = t.cyc;
    hang = 1'b0;
    wait_start(t, 100);
    chk("retry_write1", 32'({t.rw, t.addr, t.wdata}), 32'({1'b0, 6'h2D, 8'h08}));
    chk("retry_delay", 32'((t.cyc - c0) >= TOUT && (t.cyc - c0) <= TOUT + 5), 32'd1);
    chk("retry_timeout_err", 32'(timeout_err), 32'd1);
    chk("retry_not_done", 32'(init_done), 32'd0);
    wait_start(t, 50);
    chk("reinit_write2", 32'({t.rw, t.addr, t.wdata}), 32'({1'b0, 6'h31, 8'h01}));
    n = 0;
    while (!init_done && n < 30) begin step(); n++; end
    chk("reinit_done", 32'(init_done), 32'd1);

    repeat (5) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
